// File: rtl/ac_compressor_sequencer_pkg.sv
// Shared definitions for the AC compressor sequencer: state encoding and default timing.
// The optional fault path is enabled by defining AC_FAULT_EN.
package ac_compressor_sequencer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_RUN   = 3'd2,
        ST_POST  = 3'd3,
        ST_LOCK  = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

    localparam int DEF_PRE_FAN  = 2;
    localparam int DEF_MIN_ON   = 4;
    localparam int DEF_POST_FAN = 3;
    localparam int DEF_MIN_OFF  = 5;
    localparam int DEF_CNT_W    = 8;

endpackage

// File: rtl/ac_compressor_sequencer_seq_timer.sv
// Loadable down-counter with zero flag; decrement saturates at zero.
module seq_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_value;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ac_compressor_sequencer.sv
// Fan/compressor sequencing FSM with pre-run, minimum on-time, post-run and anti-short-cycle lockout.
// Define AC_FAULT_EN to add the fault/fault_clr inputs, fault_latched output and the FAULT state.
module ac_compressor_sequencer
    import ac_compressor_sequencer_pkg::*;
#(
    parameter int PRE_FAN  = DEF_PRE_FAN,
    parameter int MIN_ON   = DEF_MIN_ON,
    parameter int POST_FAN = DEF_POST_FAN,
    parameter int MIN_OFF  = DEF_MIN_OFF,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               demand,
`ifdef AC_FAULT_EN
    input  logic               fault,
    input  logic               fault_clr,
    output logic               fault_latched,
`endif
    output logic               fan_on,
    output logic               comp_on,
    output logic               lockout,
    output logic [STATE_W-1:0] state
);

    state_e           r_state;
    state_e           w_next;
    logic             w_load;
    logic [CNT_W-1:0] w_load_value;
    logic             w_dec;
    logic             w_zero;
    logic             w_go;

    assign w_go = enable && demand;

    seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_load_value (w_load_value),
        .i_dec        (w_dec),
        .o_zero       (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_load_value = '0;
        w_dec        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_next       = ST_PRE;
                    w_load       = 1'b1;
                    w_load_value = CNT_W'(PRE_FAN - 1);
                end
            end
            ST_PRE: begin
                if (!w_go) begin
                    w_next = ST_IDLE;
                end else if (w_zero) begin
                    w_next       = ST_RUN;
                    w_load       = 1'b1;
                    w_load_value = CNT_W'(MIN_ON - 1);
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_RUN: begin
                // A demand drop is only honoured once the minimum on-time has elapsed.
                if (w_zero && !w_go) begin
                    w_next       = ST_POST;
                    w_load       = 1'b1;
                    w_load_value = CNT_W'(POST_FAN - 1);
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_POST: begin
                if (w_zero) begin
                    w_next       = ST_LOCK;
                    w_load       = 1'b1;
                    w_load_value = CNT_W'(MIN_OFF - 1);
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_LOCK: begin
                if (w_zero) begin
                    w_next = ST_IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
`ifdef AC_FAULT_EN
            ST_FAULT: begin
                if (fault_clr && !fault) begin
                    w_next       = ST_LOCK;
                    w_load       = 1'b1;
                    w_load_value = CNT_W'(MIN_OFF - 1);
                end
            end
`endif
            default: begin
                w_next = ST_IDLE;
            end
        endcase
`ifdef AC_FAULT_EN
        if (fault) begin
            w_next = ST_FAULT;
            w_load = 1'b0;
            w_dec  = 1'b0;
        end
`endif
    end

    assign fan_on  = (r_state == ST_PRE) || (r_state == ST_RUN) || (r_state == ST_POST);
    assign comp_on = (r_state == ST_RUN);
    assign lockout = (r_state == ST_LOCK) || (r_state == ST_FAULT);
    assign state   = r_state;
`ifdef AC_FAULT_EN
    assign fault_latched = (r_state == ST_FAULT);
`endif

endmodule

// File: tb/tb_ac_compressor_sequencer.sv
// Directed, table-driven bench for ac_compressor_sequencer (default timing parameters).
// Fault sequences are exercised when AC_FAULT_EN is defined.
module tb_ac_compressor_sequencer;

    typedef struct {
        bit         rst;
        logic       en;
        logic       dm;
        logic       fan;
        logic       comp;
        logic       lock;
        logic [2:0] st;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       demand;
    logic       fan_on;
    logic       comp_on;
    logic       lockout;
    logic [2:0] state;
`ifdef AC_FAULT_EN
    logic       fault;
    logic       fault_clr;
    logic       fault_latched;
`endif

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    ac_compressor_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .demand        (demand),
`ifdef AC_FAULT_EN
        .fault         (fault),
        .fault_clr     (fault_clr),
        .fault_latched (fault_latched),
`endif
        .fan_on        (fan_on),
        .comp_on       (comp_on),
        .lockout       (lockout),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic f, input logic c,
                              input logic l, input logic [2:0] s);
        check({tag, " fan_on"},  int'(fan_on),  int'(f));
        check({tag, " comp_on"}, int'(comp_on), int'(c));
        check({tag, " lockout"}, int'(lockout), int'(l));
        check({tag, " state"},   int'(state),   int'(s));
    endtask

    task automatic add(input bit r, input logic e, input logic d, input logic f,
                       input logic c, input logic l, input logic [2:0] s);
        vec_t v;
        v.rst = r; v.en = e; v.dm = d; v.fan = f; v.comp = c; v.lock = l; v.st = s;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        enable = 1'b0;
        demand = 1'b0;
`ifdef AC_FAULT_EN
        fault     = 1'b0;
        fault_clr = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 3'd0);
`ifdef AC_FAULT_EN
        check("reset fault_latched", int'(fault_latched), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic e, input logic d);
        @(negedge clk);
        enable = e;
        demand = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        demand = 1'b0;
`ifdef AC_FAULT_EN
        fault     = 1'b0;
        fault_clr = 1'b0;
`endif

        // Held demand: fan after first edge, compressor two edges later, then stays in RUN.
        add(1, 1, 1, 1, 0, 0, 3'd1);
        add(0, 1, 1, 1, 0, 0, 3'd1);
        add(0, 1, 1, 1, 1, 0, 3'd2);
        for (int i = 0; i < 4; i++) add(0, 1, 1, 1, 1, 0, 3'd2);
        // Short demand during PRE: back to IDLE, no compressor, no lockout.
        add(1, 1, 1, 1, 0, 0, 3'd1);
        add(0, 1, 0, 0, 0, 0, 3'd0);
        add(0, 1, 0, 0, 0, 0, 3'd0);
        add(0, 0, 1, 0, 0, 0, 3'd0);
        // Min-on: drop right after RUN entry; then 3 POST, 5 LOCK with demand reasserted, restart.
        add(1, 1, 1, 1, 0, 0, 3'd1);
        add(0, 1, 1, 1, 0, 0, 3'd1);
        add(0, 1, 1, 1, 1, 0, 3'd2);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 1, 1, 0, 3'd2);
        add(0, 1, 0, 1, 0, 0, 3'd3);
        add(0, 1, 1, 1, 0, 0, 3'd3);
        add(0, 1, 1, 1, 0, 0, 3'd3);
        for (int i = 0; i < 5; i++) add(0, 1, 1, 0, 0, 1, 3'd4);
        add(0, 1, 1, 0, 0, 0, 3'd0);
        add(0, 1, 1, 1, 0, 0, 3'd1);
        add(0, 1, 1, 1, 0, 0, 3'd1);
        add(0, 1, 1, 1, 1, 0, 3'd2);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            step(vecs[i].en, vecs[i].dm);
            check_outs($sformatf("vec%0d", i), vecs[i].fan, vecs[i].comp, vecs[i].lock, vecs[i].st);
        end

        // Asynchronous reset mid-RUN, asserted between clock edges.
        do_reset();
        repeat (3) step(1, 1);
        check_outs("pre_async RUN", 1'b1, 1'b1, 1'b0, 3'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async reset", 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0);
        check_outs("post_reset idle", 1'b0, 1'b0, 1'b0, 3'd0);
        step(1, 1);
        check_outs("post_reset pre", 1'b1, 1'b0, 1'b0, 3'd1);

`ifdef AC_FAULT_EN
        do_reset();
        repeat (3) step(1, 1);
        @(negedge clk);
        fault = 1'b1;
        @(posedge clk);
        #1;
        check_outs("fault entry", 1'b0, 1'b0, 1'b1, 3'd5);
        check("fault_latched set", int'(fault_latched), 1);
        @(negedge clk);
        fault_clr = 1'b1;
        @(posedge clk);
        #1;
        check_outs("clr with fault", 1'b0, 1'b0, 1'b1, 3'd5);
        @(negedge clk);
        fault     = 1'b0;
        demand    = 1'b0;
        @(posedge clk);
        #1;
        check_outs("fault cleared", 1'b0, 1'b0, 1'b1, 3'd4);
        check("fault_latched clr", int'(fault_latched), 0);
        @(negedge clk);
        fault_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1, 0);
            check_outs($sformatf("fault lock%0d", i), 1'b0, 1'b0, 1'b1, 3'd4);
        end
        step(1, 0);
        check_outs("fault idle", 1'b0, 1'b0, 1'b0, 3'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
